// File: rtl/mul8x8_seq_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier.
package mul8x8_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_STEPS = 4;
  localparam int CNT_W     = $clog2(NUM_STEPS);

  // Left shift applied to each step's partial product, indexed by step number.
  localparam logic [NUM_STEPS-1:0][3:0] STEP_SHIFT = {4'd8, 4'd4, 4'd4, 4'd0};

  function automatic logic [15:0] align_pp(input logic [7:0] pp, input logic [CNT_W-1:0] k);
    return {8'd0, pp} << STEP_SHIFT[k];
  endfunction

endpackage

// File: rtl/mul8x8_seq_mul4x4.sv
// Combinational 4x4 unsigned multiplier shared across all steps.
// Latency 0; no flow control.
module mul4x4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] z
);

  assign z = {4'd0, x} * {4'd0, y};

endmodule

// File: rtl/mul8x8_seq.sv
// Sequential 8x8 unsigned multiplier: four nibble steps through one shared 4x4 multiplier.
// Latency 5 cycles accept->out_valid (1 for zero operands when MUL8X8_SEQ_ZERO_SKIP_EN is defined).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module mul8x8_seq
  import mul8x8_seq_pkg::*;
#(
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      p,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [7:0]         a_q, b_q;
  logic [TAG_W-1:0]   tag_q;
  logic [15:0]        acc;
  logic [15:0]        acc_nxt;
  logic [3:0]         a_nib, b_nib;
  logic [7:0]         pp;
  logic               accept;

  // Step bit 0 selects the high nibble of a, bit 1 the high nibble of b.
  assign a_nib = cnt[0] ? a_q[7:4] : a_q[3:0];
  assign b_nib = cnt[1] ? b_q[7:4] : b_q[3:0];

  mul4x4 u_mul4x4 (
    .x (a_nib),
    .y (b_nib),
    .z (pp)
  );

  assign acc_nxt = acc + align_pp(pp, cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept = 1'b1;
`ifdef MUL8X8_SEQ_ZERO_SKIP_EN
          if (a == 8'd0 || b == 8'd0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = STEP;
          end
`else
          state_nxt = STEP;
`endif
        end
      end
      STEP: begin
        if (cnt == LAST_STEP) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= 16'd0;
      cnt   <= '0;
      a_q   <= 8'd0;
      b_q   <= 8'd0;
      tag_q <= '0;
    end else if (accept) begin
      acc   <= 16'd0;
      cnt   <= '0;
      a_q   <= a;
      b_q   <= b;
      tag_q <= in_tag;
    end else if (state == STEP) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
    end
  end

  // Accumulator and tag are untouched in DONE, so they double as the held result.
  assign p       = acc;
  assign out_tag = tag_q;

endmodule

// File: tb/tb_mul8x8_seq.sv
// Scoreboard bench for mul8x8_seq: directed operand pairs plus a random-operand soak.
module tb_mul8x8_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a, b;
  logic [1:0]  in_tag;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] p;
  logic [1:0]  out_tag;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rdy_force = 1'b1;
  bit rand_rdy = 1'b0;
  bit ov_prev = 1'b0;

`ifdef MUL8X8_SEQ_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct {
    logic [15:0] p;
    logic [1:0]  tag;
    int          cyc;
    int          lat;
  } exp_t;

  exp_t q[$];

  mul8x8_seq #(.TAG_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    else          out_ready = rdy_force;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: checks first-valid latency and pops/compares on every handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !ov_prev) begin
        if (q.size() == 0) check("unexpected_valid", 32'(out_valid), 32'd0);
        else               check("latency", 32'(cyc - q[0].cyc), 32'(q[0].lat - 1));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_result", 32'(p), 32'hFFFF_FFFF);
        end else begin
          check("product", 32'(p), 32'(q[0].p));
          check("tag", 32'(out_tag), 32'(q[0].tag));
          void'(q.pop_front());
        end
      end
    end
    ov_prev = out_valid && !rst;
  end

  task automatic send(input logic [7:0] aa, input logic [7:0] bb, input logic [1:0] tt,
                      input logic [15:0] exp, input bit track);
    int n;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    a        = aa;
    b        = bb;
    in_tag   = tt;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    if (track) begin
      e.p   = exp;
      e.tag = tt;
      e.cyc = cyc;
      e.lat = (SKIP && (aa == 8'd0 || bb == 8'd0)) ? 1 : 5;
      q.push_back(e);
    end
    in_valid = 1'b0;
    a        = 8'($urandom);
    b        = 8'($urandom);
    in_tag   = 2'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(q.size()), 32'd0);
  endtask

  // Directed vectors: a, b, tag, hand-computed product.
  logic [7:0]  va[8]  = '{8'h80, 8'h0F, 8'h01, 8'h10, 8'hAB, 8'h7F, 8'h5C, 8'hFF};
  logic [7:0]  vb[8]  = '{8'h02, 8'hF0, 8'hFF, 8'h10, 8'hCD, 8'h81, 8'h00, 8'h01};
  logic [1:0]  vt[8]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [15:0] vp[8]  = '{16'h0100, 16'h0E10, 16'h00FF, 16'h0100,
                          16'h88EF, 16'h3FFF, 16'h0000, 16'h00FF};
  logic [15:0] acc_exp[5] = '{16'h0000, 16'h0008, 16'h0048, 16'h00A8, 16'h03A8};

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = 8'd0;
    b        = 8'd0;
    in_tag   = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_p", 32'(p), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    rst = 1'b0;

    // Max operands; out_valid must be a single-cycle pulse.
    send(8'hFF, 8'hFF, 2'd3, 16'hFE01, 1'b1);
    check("busy_in_flight", 32'(busy), 32'd1);
    drain();
    @(negedge clk);
    check("pulse_low", 32'(out_valid), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Accumulator progression through the four steps.
    send(8'h12, 8'h34, 2'd1, 16'h03A8, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("acc_step%0d", k), 32'(dut.acc), 32'(acc_exp[k]));
    end
    drain();

    for (int i = 0; i < 8; i++) send(va[i], vb[i], vt[i], vp[i], 1'b1);
    drain();

    // Backpressure: hold out_ready low for three cycles of out_valid.
    rdy_force = 1'b0;
    @(negedge clk);
    send(8'h0A, 8'h0B, 2'd2, 16'h006E, 1'b1);
    begin
      int n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("bp_valid_seen", 32'(out_valid), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      check("bp_p_hold", 32'(p), 32'h006E);
      check("bp_tag_hold", 32'(out_tag), 32'd2);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_valid_hold", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    rdy_force = 1'b1;
    begin
      int n = 0;
      while (out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("bp_release_idle", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    drain();

    // Zero operand: latency 1 with zero-skip, 5 otherwise.
    send(8'h00, 8'h7B, 2'd3, 16'h0000, 1'b1);
    drain();

    // Reset during step k=2 aborts the operation.
    send(8'hC3, 8'h5A, 2'd1, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (8) @(negedge clk);
    send(8'h0A, 8'h0B, 2'd0, 16'h006E, 1'b1);
    drain();

    // Random operands with random out_ready against a*b.
    rand_rdy = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] ra, rb;
      logic [1:0] rt;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rt = 2'($urandom);
      send(ra, rb, rt, 16'(ra) * 16'(rb), 1'b1);
    end
    drain();
    rand_rdy = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
